// File: rtl/sid_pkg.sv
// Shared types and constants for the SID bus sequencer.
// Holds bus widths, the register count, the FSM state enum and the write bundle.
package sid_pkg;

   localparam int SID_ADDR_W   = 5;
   localparam int SID_DATA_W   = 8;
   localparam int SID_NUM_REGS = 25;

   typedef enum logic [2:0] {
      RESET,
      IDLE,
      SETUP,
      ACTIVE,
      HOLD
   } sid_state_e;

   typedef struct packed {
      logic [SID_ADDR_W-1:0] addr;
      logic [SID_DATA_W-1:0] data;
   } sid_wr_t;

   function automatic logic sid_addr_ok(
      input logic [SID_ADDR_W-1:0] a
   );
      return a < SID_ADDR_W'(SID_NUM_REGS);
   endfunction

endpackage

// File: rtl/sid_wr_fifo.sv
// Synchronous write queue of {addr, data} SID register writes.
// Push on full and pop on empty are ignored; rst discards all entries.
module sid_wr_fifo
   import sid_pkg::*;
#(
   parameter int FIFO_DEPTH = 16
) (
   input  logic    clk,
   input  logic    rst,
   input  logic    push,
   input  logic    pop,
   input  sid_wr_t din,
   output sid_wr_t dout,
   output logic    full,
   output logic    empty
);

   localparam int AW = $clog2(FIFO_DEPTH);

   sid_wr_t          mem [FIFO_DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (AW+1)'(FIFO_DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   // storage array, written on accepted push
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   // pointers and occupancy
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         unique case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/sid_bus_sequencer.sv
// Buffers SID register writes and replays them on the SID bus with phi2 timing.
// Optional macro SID_REFRESH_EN: rewrite a shadow copy of all registers when idle.
module sid_bus_sequencer
   import sid_pkg::*;
#(
   parameter int CLK_DIV     = 16,
   parameter int FIFO_DEPTH  = 16,
   parameter int RST_PERIODS = 10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       wr_valid,
   input  logic [4:0] wr_addr,
   input  logic [7:0] wr_data,
   output logic       wr_ready,
   output logic       sid_clk,
   output logic [4:0] sid_addr,
   output logic [7:0] sid_data,
   output logic       sid_cs,
   output logic       sid_rw,
   output logic       sid_rst,
   output logic       busy,
   output logic       overflow
);

   localparam int PW = $clog2(CLK_DIV);
   localparam int CW = $clog2(RST_PERIODS + 1);
   localparam logic [PW-1:0] PH_LAST = PW'(CLK_DIV - 1);
   localparam logic [PW-1:0] PH_HALF = PW'(CLK_DIV / 2);
   localparam logic [CW-1:0] CNT_LAST = CW'(RST_PERIODS - 1);

   sid_state_e    state, state_nxt;
   logic [PW-1:0] phase, phase_nxt;
   logic [CW-1:0] rst_cnt, cnt_nxt;
   logic [4:0]    addr_nxt;
   logic [7:0]    data_nxt;
   logic          cs_nxt;
   logic          rw_nxt;
   logic          srst_nxt;
   logic          push;
   logic          pop;
   logic          fifo_full;
   logic          fifo_empty;
   sid_wr_t       fifo_dout;
   logic          in_cycle;

`ifdef SID_REFRESH_EN
   logic [7:0] shadow [SID_NUM_REGS];
   logic [4:0] refresh_ptr, ptr_nxt;
   logic       is_refresh, refr_nxt;
`endif

   assign phase_nxt = (phase == PH_LAST) ? '0 : phase + 1'b1;
   assign wr_ready  = (state != RESET) && !fifo_full;
   assign push      = wr_valid && wr_ready && sid_addr_ok(wr_addr);
   assign in_cycle  = (state == SETUP) || (state == ACTIVE)
                   || (state == HOLD);

`ifdef SID_REFRESH_EN
   assign busy = !fifo_empty || (in_cycle && !is_refresh);
`else
   assign busy = !fifo_empty || in_cycle;
`endif

   sid_wr_fifo #(
      .FIFO_DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk  (clk),
      .rst  (rst),
      .push (push),
      .pop  (pop),
      .din  ('{addr: wr_addr, data: wr_data}),
      .dout (fifo_dout),
      .full (fifo_full),
      .empty(fifo_empty)
   );

   // phase counter and registered phi2, high for the upper half period
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase   <= '0;
         sid_clk <= 1'b0;
      end else begin
         phase   <= phase_nxt;
         sid_clk <= (phase_nxt >= PH_HALF);
      end
   end

   // sticky flag for requests arriving while not ready
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow <= 1'b0;
      end else if (wr_valid && !wr_ready) begin
         overflow <= 1'b1;
      end
   end

   // FSM state and registered bus outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= RESET;
         rst_cnt  <= '0;
         sid_addr <= '0;
         sid_data <= '0;
         sid_cs   <= 1'b1;
         sid_rw   <= 1'b1;
         sid_rst  <= 1'b0;
`ifdef SID_REFRESH_EN
         refresh_ptr <= '0;
         is_refresh  <= 1'b0;
`endif
      end else begin
         state    <= state_nxt;
         rst_cnt  <= cnt_nxt;
         sid_addr <= addr_nxt;
         sid_data <= data_nxt;
         sid_cs   <= cs_nxt;
         sid_rw   <= rw_nxt;
         sid_rst  <= srst_nxt;
`ifdef SID_REFRESH_EN
         refresh_ptr <= ptr_nxt;
         is_refresh  <= refr_nxt;
`endif
      end
   end

   // next state: decisions are keyed to the phase being entered
   always_comb begin
      state_nxt = state;
      cnt_nxt   = rst_cnt;
      addr_nxt  = sid_addr;
      data_nxt  = sid_data;
      cs_nxt    = sid_cs;
      rw_nxt    = sid_rw;
      srst_nxt  = sid_rst;
      pop       = 1'b0;
`ifdef SID_REFRESH_EN
      ptr_nxt   = refresh_ptr;
      refr_nxt  = is_refresh;
`endif
      unique case (state)
         RESET: begin
            if (phase_nxt == '0) begin
               if (rst_cnt == CNT_LAST) begin
                  srst_nxt  = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  cnt_nxt = rst_cnt + 1'b1;
               end
            end
         end
         IDLE: begin
            if (phase_nxt == '0) begin
               if (!fifo_empty) begin
                  pop       = 1'b1;
                  addr_nxt  = fifo_dout.addr;
                  data_nxt  = fifo_dout.data;
                  rw_nxt    = 1'b0;
                  state_nxt = SETUP;
`ifdef SID_REFRESH_EN
                  refr_nxt  = 1'b0;
               end else begin
                  addr_nxt  = refresh_ptr;
                  data_nxt  = shadow[refresh_ptr];
                  rw_nxt    = 1'b0;
                  refr_nxt  = 1'b1;
                  state_nxt = SETUP;
                  ptr_nxt   = (refresh_ptr == 5'(SID_NUM_REGS - 1))
                            ? '0 : refresh_ptr + 1'b1;
`endif
               end
            end
         end
         SETUP: begin
            if (phase_nxt == PH_HALF) begin
               cs_nxt    = 1'b0;
               state_nxt = ACTIVE;
            end
         end
         ACTIVE: begin
            if (phase_nxt == '0) begin
               cs_nxt    = 1'b1;
               state_nxt = HOLD;
            end
         end
         HOLD: begin
            rw_nxt    = 1'b1;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = RESET;
         end
      endcase
   end

`ifdef SID_REFRESH_EN
   // shadow copy of each value latched by the SID
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shadow <= '{default: '0};
      end else if (state == ACTIVE && state_nxt == HOLD) begin
         shadow[sid_addr] <= sid_data;
      end
   end
`endif

endmodule

// File: tb/tb_sid_bus_sequencer.sv
// Self-checking bench for sid_bus_sequencer.
// Reference model schedules bus slots from period arithmetic and a queue.
module tb_sid_bus_sequencer;

   localparam int CD    = 16;
   localparam int HALF  = CD / 2;
   localparam int RP    = 10;
   localparam int DEPTH = 16;
   localparam int RST_N = RP * CD;

   typedef struct {
      logic [4:0] a;
      logic [7:0] d;
   } wr_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       wr_valid = 1'b0;
   logic [4:0] wr_addr = '0;
   logic [7:0] wr_data = '0;
   logic       wr_ready;
   logic       sid_clk;
   logic [4:0] sid_addr;
   logic [7:0] sid_data;
   logic       sid_cs;
   logic       sid_rw;
   logic       sid_rst;
   logic       busy;
   logic       overflow;

   always #5 clk = ~clk;

   sid_bus_sequencer #(
      .CLK_DIV(CD),
      .FIFO_DEPTH(DEPTH),
      .RST_PERIODS(RP)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .wr_valid(wr_valid),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .wr_ready(wr_ready),
      .sid_clk (sid_clk),
      .sid_addr(sid_addr),
      .sid_data(sid_data),
      .sid_cs  (sid_cs),
      .sid_rw  (sid_rw),
      .sid_rst (sid_rst),
      .busy    (busy),
      .overflow(overflow)
   );

   int checks = 0;
   int failures = 0;

   // model state: edges since reset release, queue, current bus write
   int         n;
   wr_t        mq[$];
   bit         txn;
   int         s;
   logic [4:0] ta;
   logic [7:0] td;
   bit         tref;
   bit         ovf;
`ifdef SID_REFRESH_EN
   logic [7:0] shd [25];
   int         rptr;
`endif

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h t=%0t",
                  tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      n = 0;
      mq.delete();
      txn  = 0;
      s    = 0;
      ta   = '0;
      td   = '0;
      tref = 0;
      ovf  = 0;
`ifdef SID_REFRESH_EN
      foreach (shd[i]) shd[i] = '0;
      rptr = 0;
`endif
   endtask

   task automatic start_txn(input logic [4:0] a,
                            input logic [7:0] d,
                            input bit r);
      txn  = 1;
      s    = n;
      ta   = a;
      td   = d;
      tref = r;
`ifdef SID_REFRESH_EN
      shd[a] = d;
`endif
   endtask

   task automatic model_edge();
      bit  rdy;
      wr_t w;
      rdy = (n >= RST_N) && (mq.size() < DEPTH);
      n++;
      if (wr_valid && !rdy) ovf = 1;
      if ((n % CD == 0) && (n > RST_N)
          && (!txn || n >= s + 2 * CD)) begin
         if (mq.size() > 0) begin
            w = mq.pop_front();
            start_txn(w.a, w.d, 0);
         end
`ifdef SID_REFRESH_EN
         else begin
            start_txn(5'(rptr), shd[rptr], 1);
            rptr = (rptr + 1) % 25;
         end
`endif
      end
      if (wr_valid && rdy && wr_addr < 5'd25) begin
         w.a = wr_addr;
         w.d = wr_data;
         mq.push_back(w);
      end
   endtask

   task automatic check_outputs();
      bit cs_lo, rw_lo;
      cs_lo = txn && (n >= s + HALF) && (n <= s + CD - 1);
      rw_lo = txn && (n <= s + CD);
      chk("sid_clk", 32'(sid_clk), 32'((n % CD) >= HALF));
      chk("sid_rst", 32'(sid_rst), 32'(n >= RST_N));
      chk("wr_ready", 32'(wr_ready),
          32'((n >= RST_N) && (mq.size() < DEPTH)));
      chk("sid_cs", 32'(sid_cs), 32'(!cs_lo));
      chk("sid_rw", 32'(sid_rw), 32'(!rw_lo));
      chk("sid_addr", 32'(sid_addr), 32'(ta));
      chk("sid_data", 32'(sid_data), 32'(td));
      chk("busy", 32'(busy),
          32'((mq.size() > 0) || (rw_lo && !tref)));
      chk("overflow", 32'(overflow), 32'(ovf));
   endtask

   task automatic step();
      @(posedge clk);
      if (!rst) model_edge();
      @(negedge clk);
      check_outputs();
   endtask

   task automatic push1(input logic [4:0] a, input logic [7:0] d);
      wr_valid = 1'b1;
      wr_addr  = a;
      wr_data  = d;
      step();
      wr_valid = 1'b0;
   endtask

   initial begin
      int k;
      model_reset();
      rst = 1'b1;
      repeat (3) step();
      rst = 1'b0;

      // reset sequence and idle after it
      repeat (RST_N + 20) step();

      // single write
      push1(5'h18, 8'h0F);
      repeat (60) step();

      // out-of-range addresses are dropped silently
      push1(5'd25, 8'h11);
      push1(5'd31, 8'h22);
      repeat (40) step();
      chk("drop_ovf", 32'(overflow), 32'd0);

      // burst aligned right after a bus cycle starts
      push1(5'd1, 8'h55);
      k = 0;
      while (!(txn && n == s) && k < 100) begin
         step();
         k++;
      end
      chk("burst_align_timeout", 32'(k >= 100), 32'd0);
      for (int i = 0; i < 17; i++) begin
         wr_valid = 1'b1;
         wr_addr  = 5'(i);
         wr_data  = 8'(8'hA0 + i);
         if (i == 16) chk("burst_ready17", 32'(wr_ready), 32'd0);
         step();
      end
      wr_valid = 1'b0;
      chk("burst_ovf", 32'(overflow), 32'd1);
      repeat (16 * 2 * CD + 40) step();

      // reset in the middle of an active bus cycle
      for (int i = 0; i < 6; i++) push1(5'(i + 2), 8'(8'h30 + i));
      k = 0;
      while (!(txn && n >= s + HALF && n < s + CD - 1
               && mq.size() == 5) && k < 100) begin
         step();
         k++;
      end
      chk("midrst_wait_timeout", 32'(k >= 100), 32'd0);
      #2;
      rst = 1'b1;
      #1;
      chk("midrst_cs", 32'(sid_cs), 32'd1);
      chk("midrst_sid_rst", 32'(sid_rst), 32'd0);
      chk("midrst_ready", 32'(wr_ready), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      model_reset();
      repeat (3) step();
      rst = 1'b0;
      repeat (RST_N + 100) step();

      // random traffic
      repeat (1500) begin
         wr_valid = ($urandom % 6) == 0;
         wr_addr  = 5'($urandom % 32);
         wr_data  = 8'($urandom);
         step();
      end
      wr_valid = 1'b0;
      repeat (700) step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sid_bus_sequencer.md
Name: sid_bus_sequencer

Overview:
Downstream stage of the SPI register decoder. Accepts (addr, data) SID register writes through a valid/ready handshake and buffers them in a small FIFO. Generates the SID phi2 clock (sid_clk) and replays each write onto the SID bus with correct cs/rw timing, at most one write per sid_clk period. Also owns the SID hardware reset pulse after system reset.

Parameters:
CLK_DIV, 16, clk cycles per sid_clk period; even, >= 4.
FIFO_DEPTH, 16, write-queue entries; power of 2, >= 2.
RST_PERIODS, 10, sid_clk periods sid_rst is held low after reset.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
wr_valid  in  1  write request from SPI decoder
wr_addr  in  5  SID register address (0..24 valid)
wr_data  in  8  SID register data
wr_ready  out  1  FIFO can accept; high when not full and not in SID reset
sid_clk  out  1  phi2 to SID
sid_addr  out  5  SID address bus
sid_data  out  8  SID data bus
sid_cs  out  1  chip select, active-low
sid_rw  out  1  1 = read/idle, 0 = write
sid_rst  out  1  SID reset, active-low
busy  out  1  FIFO non-empty or bus cycle in progress
overflow  out  1  sticky: wr_valid seen while wr_ready low; cleared only by rst

Behaviour:
- Reset values: sid_clk 0, sid_addr 0, sid_data 0, sid_cs 1, sid_rw 1, sid_rst 0, wr_ready 0, busy 0, overflow 0; FIFO empty; divider 0; FSM RESET.
- Divider: phase counter 0..CLK_DIV-1, free-running from reset release. sid_clk = 0 for phase < CLK_DIV/2, 1 otherwise; registered output, no glitches.
- Handshake: push when wr_valid && wr_ready. Addresses > 24 are accepted and dropped: no push, no overflow.
- Simultaneous push and pop on a full FIFO: the pop frees the slot, but wr_ready reflects the pre-pop state, so the push is refused.
- FSM states:
  - RESET: sid_rst 0. Count RST_PERIODS sid_clk periods, then raise sid_rst and go to IDLE at the next phase 0. wr_ready 0 throughout.
  - IDLE: at phase 0 with FIFO non-empty, pop the head, drive sid_addr/sid_data, set sid_rw 0 in the same cycle, go to SETUP.
  - SETUP: at phase CLK_DIV/2 (sid_clk rising), sid_cs becomes 0; go to ACTIVE.
  - ACTIVE: at the next phase 0 (sid_clk falling; SID latches here), sid_cs becomes 1; go to HOLD.
  - HOLD: one clk later, sid_rw becomes 1 and sid_addr/sid_data hold their values; go to IDLE. A queued write therefore starts at the following phase 0, i.e. the next period: throughput is one write per 2 sid_clk periods.
- Latency: a push into an empty idle FIFO yields sid_cs low at the first phase CLK_DIV/2 following the first phase 0 after the push.
- Reset mid-cycle: rst immediately forces reset values. The FIFO contents are discarded and the bus cycle is aborted with sid_cs 1.
- busy = FIFO non-empty or state in {SETUP, ACTIVE, HOLD}.

Optional Feature:
SID_REFRESH_EN
- Defined: a 25x8 shadow register file records every value actually written to the bus, reset to 0. When the state is IDLE at phase 0 and the FIFO is empty, the block rewrites shadow[refresh_ptr] with a normal bus cycle and then advances refresh_ptr, wrapping 24 -> 0. FIFO writes always take priority. Refresh cycles do not assert busy.
- Undefined: no shadow storage; the bus is idle whenever the FIFO is empty.

Decomposition:
- Package sid_pkg: SID_ADDR_W=5, SID_DATA_W=8, SID_NUM_REGS=25, and an FSM state enum {RESET, IDLE, SETUP, ACTIVE, HOLD}.
- One sub-module: sid_wr_fifo, a synchronous FIFO parameterised on FIFO_DEPTH with push/pop/full/empty, storing {addr, data}.

Test Plan:
1. Release rst at t0 -> sid_rst low for exactly 10 sid_clk periods (160 clk at CLK_DIV 16), wr_ready rises with sid_rst, and sid_cs stays 1 throughout.
2. Single push addr 0x18, data 0x0F after reset -> sid_rw 0 from phase 0, sid_cs low for exactly 8 clk during sid_clk high, bus shows 0x18/0x0F at the sid_clk falling edge, sid_rw back to 1 one clk later.
3. Burst of 16 pushes (addr i, data 0xA0+i) with wr_valid held high -> all 16 accepted, wr_ready low for a 17th, overflow set on that attempt, and 16 bus cycles in order spaced 2 sid_clk periods apart.
4. Push addr 25 and addr 31 -> no bus cycle, overflow stays 0, busy stays 0.
5. Assert rst while sid_cs is low with 5 entries queued -> sid_cs 1 and sid_rst 0 immediately, and after the new reset sequence no stale writes appear.
6. With SID_REFRESH_EN: write reg 4 = 0x41, then idle -> reg 4 reappears with 0x41 every 25 refresh slots and the other registers are written with 0x00; a new push preempts refresh at the next phase 0.
